// File: rtl/eight_bit_threshold_monitor.sv
// eight_bit_threshold_monitor
//   Consumes a stream of unsigned 8-bit samples, tracks running max/min and a
//   saturating sample count, and runs a hysteresis alarm FSM with a
//   persistence filter on samples strictly above thr_hi.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      sample qualifier
//   in_data       unsigned sample
//   thr_hi/thr_lo upper/lower thresholds, taken with each accepted sample
//   clear         synchronous clear of max/min/stats_valid/sample_count
//   alarm         registered alarm flag (1 while FSM is in ALARM)
//   cfg_err       registered, 1 when thr_lo > thr_hi at the last accepted sample
//   max_val       running maximum since reset/clear
//   min_val       running minimum since reset/clear
//   stats_valid   1 once a sample has been accepted since reset/clear
//   sample_count  accepted samples since reset/clear, saturating
//   alarm_events  ALARM entries since reset, saturating at 255
module eight_bit_threshold_monitor #(
  parameter int unsigned PERSIST = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [7:0]       thr_hi,
  input  logic [7:0]       thr_lo,
  input  logic             clear,
  output logic             alarm,
  output logic             cfg_err,
  output logic [7:0]       max_val,
  output logic [7:0]       min_val,
  output logic             stats_valid,
  output logic [CNT_W-1:0] sample_count,
  output logic [7:0]       alarm_events
);

  localparam int unsigned PC_W = 4;
  localparam logic [PC_W-1:0]  PERSIST_V = PC_W'(PERSIST);
  localparam bit               PERSIST_1 = (PERSIST == 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NORMAL  = 2'd1,
    PENDING = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pcnt, pcnt_n;
  logic              alarm_n, cfg_err_n, stats_valid_n;
  logic [7:0]        max_n, min_n, events_n;
  logic [CNT_W-1:0]  count_n;

  // Comparator flags, all unsigned and combinational on the current sample
  logic above_c, below_c, cfg_bad_c, gt_max_c, lt_min_c;

  always_comb begin
    above_c   = in_data > thr_hi;
    below_c   = in_data < thr_lo;
    cfg_bad_c = thr_lo > thr_hi;
    gt_max_c  = in_data > max_val;
    lt_min_c  = in_data < min_val;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    pcnt_n        = pcnt;
    cfg_err_n     = cfg_err;
    max_n         = max_val;
    min_n         = min_val;
    stats_valid_n = stats_valid;
    count_n       = sample_count;
    events_n      = alarm_events;
    alarm_n       = alarm;

    if (clear) begin
      max_n         = 8'h00;
      min_n         = 8'hFF;
      stats_valid_n = 1'b0;
      count_n       = '0;
    end

    if (in_valid) begin
      cfg_err_n = cfg_bad_c;

      // A sample arriving with clear is the first sample of the new window
      if (clear || !stats_valid) begin
        max_n         = in_data;
        min_n         = in_data;
        stats_valid_n = 1'b1;
      end else begin
        if (gt_max_c) max_n = in_data;
        if (lt_min_c) min_n = in_data;
      end

      if (clear)                      count_n = CNT_W'(1);
      else if (sample_count != CNT_MAX) count_n = sample_count + CNT_W'(1);

      if (cfg_bad_c) begin
        state_n = NORMAL;
        pcnt_n  = '0;
      end else begin
        unique case (state)
          IDLE, NORMAL: begin
            if (above_c) begin
              if (PERSIST_1) begin
                state_n = ALARM;
                pcnt_n  = '0;
              end else begin
                state_n = PENDING;
                pcnt_n  = PC_W'(1);
              end
            end else begin
              state_n = NORMAL;
              pcnt_n  = '0;
            end
          end
          PENDING: begin
            if (above_c) begin
              if (pcnt + PC_W'(1) >= PERSIST_V) begin
                state_n = ALARM;
                pcnt_n  = '0;
              end else begin
                pcnt_n = pcnt + PC_W'(1);
              end
            end else begin
              state_n = NORMAL;
              pcnt_n  = '0;
            end
          end
          ALARM: begin
            // Only a sample below thr_lo releases the alarm (hysteresis)
            if (below_c) begin
              state_n = NORMAL;
              pcnt_n  = '0;
            end
          end
          default: begin
            state_n = IDLE;
            pcnt_n  = '0;
          end
        endcase
      end
    end

    alarm_n = (state_n == ALARM);
    if ((state_n == ALARM) && (state != ALARM) && (alarm_events != 8'hFF))
      events_n = alarm_events + 8'd1;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pcnt         <= '0;
      alarm        <= 1'b0;
      cfg_err      <= 1'b0;
      max_val      <= 8'h00;
      min_val      <= 8'hFF;
      stats_valid  <= 1'b0;
      sample_count <= '0;
      alarm_events <= 8'h00;
    end else begin
      state        <= state_n;
      pcnt         <= pcnt_n;
      alarm        <= alarm_n;
      cfg_err      <= cfg_err_n;
      max_val      <= max_n;
      min_val      <= min_n;
      stats_valid  <= stats_valid_n;
      sample_count <= count_n;
      alarm_events <= events_n;
    end
  end

endmodule

// File: tb/tb_eight_bit_threshold_monitor.sv
// Scoreboard bench for eight_bit_threshold_monitor (PERSIST=3, CNT_W=4).
// Each directed step pushes its hand-computed expected outputs; a monitor
// pops and compares one cycle after the driving edge.
module tb_eight_bit_threshold_monitor;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic [7:0]       thr_hi = 8'h80;
  logic [7:0]       thr_lo = 8'h20;
  logic             clear = 1'b0;
  logic             alarm, cfg_err, stats_valid;
  logic [7:0]       max_val, min_val, alarm_events;
  logic [CNT_W-1:0] sample_count;

  eight_bit_threshold_monitor #(.PERSIST(3), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .thr_hi       (thr_hi),
    .thr_lo       (thr_lo),
    .clear        (clear),
    .alarm        (alarm),
    .cfg_err      (cfg_err),
    .max_val      (max_val),
    .min_val      (min_val),
    .stats_valid  (stats_valid),
    .sample_count (sample_count),
    .alarm_events (alarm_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       alarm;
    logic       cfg_err;
    logic [7:0] max_val;
    logic [7:0] min_val;
    logic       stats_valid;
    logic [3:0] count;
    logic [7:0] events;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d actual %0h expected %0h", name, id, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic c, input logic v, input logic [7:0] d,
                      input logic [7:0] hi, input logic [7:0] lo,
                      input logic ea, input logic ec, input logic [7:0] emax,
                      input logic [7:0] emin, input logic esv, input logic [3:0] ecnt,
                      input logic [7:0] eev);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = d; thr_hi = hi; thr_lo = lo;
    e.id = step_id; e.alarm = ea; e.cfg_err = ec; e.max_val = emax; e.min_val = emin;
    e.stats_valid = esv; e.count = ecnt; e.events = eev;
    exp_q.push_back(e);
    step_id++;
  endtask

  // Monitor: outputs are presented one cycle after each driven step
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        #1;
        e = exp_q.pop_front();
        chk("alarm",        e.id, 16'(alarm),        16'(e.alarm));
        chk("cfg_err",      e.id, 16'(cfg_err),      16'(e.cfg_err));
        chk("max_val",      e.id, 16'(max_val),      16'(e.max_val));
        chk("min_val",      e.id, 16'(min_val),      16'(e.min_val));
        chk("stats_valid",  e.id, 16'(stats_valid),  16'(e.stats_valid));
        chk("sample_count", e.id, 16'(sample_count), 16'(e.count));
        chk("alarm_events", e.id, 16'(alarm_events), 16'(e.events));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual running expected finished");
    $fatal(1);
  end

  initial begin
    int guard;
    //    rst clr v  data   hi     lo     alm cfg max    min    sv  cnt    ev
    step(1, 0, 0, 8'h00, 8'h80, 8'h20, 0,  0,  8'h00, 8'hFF, 0,  4'd0,  8'd0);
    // Basic tracking; 0x90 leaves FSM in PENDING
    step(0, 0, 1, 8'h40, 8'h80, 8'h20, 0,  0,  8'h40, 8'h40, 1,  4'd1,  8'd0);
    step(0, 0, 1, 8'h10, 8'h80, 8'h20, 0,  0,  8'h40, 8'h10, 1,  4'd2,  8'd0);
    step(0, 0, 1, 8'h90, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd3,  8'd0);
    step(0, 0, 0, 8'hFF, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd3,  8'd0);
    step(0, 0, 1, 8'h50, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd4,  8'd0);
    // Three samples above thr_hi raise the alarm
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd5,  8'd0);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd6,  8'd0);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 1,  0,  8'h90, 8'h10, 1,  4'd7,  8'd1);
    // Hysteresis: inside band and equal to thr_lo hold, below releases
    step(0, 0, 1, 8'h50, 8'h80, 8'h20, 1,  0,  8'h90, 8'h10, 1,  4'd8,  8'd1);
    step(0, 0, 1, 8'h20, 8'h80, 8'h20, 1,  0,  8'h90, 8'h10, 1,  4'd9,  8'd1);
    step(0, 0, 1, 8'h1F, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd10, 8'd1);
    // Equality to thr_hi is not above
    step(0, 0, 1, 8'h80, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd11, 8'd1);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd12, 8'd1);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd13, 8'd1);
    step(0, 0, 1, 8'h80, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd14, 8'd1);
    // Count saturates at 15 while the alarm builds again
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd15, 8'd1);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h90, 8'h10, 1,  4'd15, 8'd1);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 1,  0,  8'h90, 8'h10, 1,  4'd15, 8'd2);
    step(0, 0, 1, 8'hF0, 8'h80, 8'h20, 1,  0,  8'hF0, 8'h10, 1,  4'd15, 8'd2);
    // clear with a sample: sample is first of new window, alarm untouched
    step(0, 1, 1, 8'h33, 8'h80, 8'h20, 1,  0,  8'h33, 8'h33, 1,  4'd1,  8'd2);
    step(0, 1, 0, 8'h00, 8'h80, 8'h20, 1,  0,  8'h00, 8'hFF, 0,  4'd0,  8'd2);
    // Inverted thresholds force NORMAL while still tracking stats
    step(0, 0, 1, 8'hFF, 8'h10, 8'h90, 0,  1,  8'hFF, 8'hFF, 1,  4'd1,  8'd2);
    step(0, 0, 1, 8'h05, 8'h80, 8'h20, 0,  0,  8'hFF, 8'h05, 1,  4'd2,  8'd2);
    step(0, 0, 0, 8'hFF, 8'h10, 8'h90, 0,  0,  8'hFF, 8'h05, 1,  4'd2,  8'd2);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'hFF, 8'h05, 1,  4'd3,  8'd2);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'hFF, 8'h05, 1,  4'd4,  8'd2);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 1,  0,  8'hFF, 8'h05, 1,  4'd5,  8'd3);
    // Reset mid-alarm overrides a concurrent sample
    step(1, 0, 1, 8'hFF, 8'h10, 8'h90, 0,  0,  8'h00, 8'hFF, 0,  4'd0,  8'd0);
    // After reset the FSM restarts from IDLE (0x81 only goes to PENDING)
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h81, 8'h81, 1,  4'd1,  8'd0);
    step(0, 0, 1, 8'h81, 8'h80, 8'h20, 0,  0,  8'h81, 8'h81, 1,  4'd2,  8'd0);
    step(0, 0, 1, 8'h82, 8'h80, 8'h20, 1,  0,  8'h82, 8'h81, 1,  4'd3,  8'd1);

    @(negedge clk);
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending actual %0d expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
